seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_mult_pkg.sv | 13 +
 rtl/seq_multiplier_if.sv | 16 +
 rtl/seq_multiplier.sv | 104 ++++++++++
 tb/tb_seq_multiplier.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared constants and FSM state type for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W         = 6;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for seq_multiplier; the master drives operands, the slave returns the product.
interface seq_multiplier_if
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] p;
  logic               rdy;

  modport master (output a, output b, input  p, input  rdy);
  modport slave  (input  a, input  b, output p, output rdy);

endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, result held until reset.
// Optional macro SEQ_MULT_SIGNED_EN selects a two's-complement (signed) product.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               rdy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] sum;

`ifdef SEQ_MULT_SIGNED_EN
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] a_mag, b_mag;

  // The most negative value maps onto itself, which is still its correct unsigned magnitude.
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d    = neg_q;
`endif
    sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      LOAD: begin
`ifdef SEQ_MULT_SIGNED_EN
        mcand_d  = {{WIDTH{1'b0}}, a_mag};
        mplier_d = b_mag;
        neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
`else
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
`endif
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = BUSY;
      end
      BUSY: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
`ifdef SEQ_MULT_SIGNED_EN
          if (neg_q) acc_d = -sum;
`endif
        end
      end
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  // rdy and p decode straight from registered state, so reset clears them without a clock.
  assign rdy = (state_q == DONE);
  assign p   = rdy ? acc_q : '0;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: driver pushes reference products, monitor checks rdy/p/latency.
module tb_seq_multiplier;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (bus.a),
    .b     (bus.b),
    .p     (bus.p),
    .rdy   (bus.rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product straight from the arithmetic definition.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [2*W-1:0] x, y;
    x = $signed(av);
    y = $signed(bv);
    return x * y;
`else
    logic [2*W-1:0] x, y;
    x = av;
    y = bv;
    return x * y;
`endif
  endfunction

  // Monitor: counts edges since reset release and checks the product when rdy rises.
  initial begin : monitor
    int edges = 0;
    bit seen_rdy = 1'b0;
    logic [2*W-1:0] held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        edges    = 0;
        seen_rdy = 1'b0;
        check("reset_rdy", {{(2*W-1){1'b0}}, bus.rdy}, '0);
        check("reset_p", bus.p, '0);
        continue;
      end
      edges++;
      if (seen_rdy) begin
        check("done_rdy_hold", {{(2*W-1){1'b0}}, bus.rdy}, 1);
        check("done_p_hold", bus.p, held);
      end else if (bus.rdy) begin
        seen_rdy = 1'b1;
        check("rdy_latency", 2*W'(edges), 2*W'(LATENCY));
        if (exp_q.size() == 0) begin
          check("unexpected_rdy", 1, 0);
        end else begin
          held = exp_q.pop_front();
          check("product", bus.p, held);
        end
      end else begin
        check("busy_p_zero", bus.p, '0);
        if (edges > LATENCY + 3 && exp_q.size() != 0) begin
          check("rdy_timeout", 2*W'(edges), 2*W'(LATENCY));
          void'(exp_q.pop_front());
          seen_rdy = 1'b1;
          held     = bus.p;
        end
      end
    end
  end

  // mode 0: inputs static; 1: a forced to 100 at edge 5; 2: both randomised at edge 5.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int mode);
    int waited;
    @(negedge clk);
    reset = 1'b1;
    bus.a = av;
    bus.b = bv;
    @(negedge clk);
    exp_q.push_back(model(av, bv));
    reset = 1'b0;
    repeat (5) @(negedge clk);
    if (mode == 1) bus.a = 100;
    if (mode == 2) begin
      bus.a = $urandom;
      bus.b = $urandom;
    end
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      check("driver_wait_timeout", 2*W'(exp_q.size()), '0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    // Mid-cycle reset in DONE: outputs must clear without any clock edge.
    #2 reset = 1'b1;
    #1;
    check("async_abort_rdy", {{(2*W-1){1'b0}}, bus.rdy}, '0);
    check("async_abort_p", bus.p, '0);
  endtask

  initial begin : driver
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    check("por_rdy", {{(2*W-1){1'b0}}, bus.rdy}, '0);
    check("por_p", bus.p, '0);

    run_op(32'd3, 32'd5, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(32'h1234_5678, 32'd0, 0);
    run_op(32'd0, 32'hDEAD_BEEF, 0);
    run_op(32'd7, 32'd9, 1);
    run_op(32'hFFFF_FFFE, 32'd3, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 0);

    // Abort mid-BUSY after 10 busy edges, then restart with 2*4.
    @(negedge clk);
    reset = 1'b1;
    bus.a = 32'd11;
    bus.b = 32'd13;
    @(negedge clk);
    reset = 1'b0;
    repeat (11) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("busy_abort_rdy", {{(2*W-1){1'b0}}, bus.rdy}, '0);
    check("busy_abort_p", bus.p, '0);
    run_op(32'd2, 32'd4, 0);

    for (int i = 0; i < 12; i++) begin
      run_op($urandom, $urandom, (i % 2 == 0) ? 2 : 0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
